// File: rtl/apb_ahb_bridge_core_if.sv
// AHB-Lite slave port plus APB master port of apb_ahb_bridge_core in one bundle.
// slave: bridge side; master: AHB master and APB slave array side.
interface apb_ahb_bridge_core_if #(
    parameter int unsigned HADDR_W = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned PADDR_W = 16,
    parameter int unsigned NUM_SLV = 4
) ();
    // AHB-Lite
    logic                        hsel;
    logic                        hready;
    logic [1:0]                  htrans;
    logic                        hwrite;
    logic [HADDR_W-1:0]          haddr;
    logic [DATA_W-1:0]           hwdata;
    logic                        hreadyout;
    logic                        hresp;
    logic [DATA_W-1:0]           hrdata;

    // APB
    logic [NUM_SLV-1:0]          psel;
    logic                        penable;
    logic [PADDR_W-1:0]          paddr;
    logic                        pwrite;
    logic [DATA_W-1:0]           pwdata;
    logic [NUM_SLV*DATA_W-1:0]   prdata;
    logic [NUM_SLV-1:0]          pready;
    logic [NUM_SLV-1:0]          pslverr;

    modport slave (
        input  hsel, hready, htrans, hwrite, haddr, hwdata,
        output hreadyout, hresp, hrdata,
        output psel, penable, paddr, pwrite, pwdata,
        input  prdata, pready, pslverr
    );

    modport master (
        output hsel, hready, htrans, hwrite, haddr, hwdata,
        input  hreadyout, hresp, hrdata,
        input  psel, penable, paddr, pwrite, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_ahb_bridge_core.sv
// AHB-Lite slave to multi-slave APB master bridge with wait states and error mapping.
// Optional ACCESS-phase timeout enabled by defining APB_TIMEOUT_EN.
module apb_ahb_bridge_core #(
    parameter int unsigned HADDR_W     = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned PADDR_W     = 16,
    parameter int unsigned NUM_SLV     = 4,
    parameter int unsigned SLV_LSB     = 12,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic                  hclk,
    input  logic                  hreset_n,
    apb_ahb_bridge_core_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WWAIT  = 3'd1,
        S_SETUP  = 3'd2,
        S_ACCESS = 3'd3,
        S_ERR1   = 3'd4,
        S_ERR2   = 3'd5
    } state_t;

    state_t              state, state_nxt;
    logic [NUM_SLV-1:0]  sel_oh, sel_oh_nxt;

    logic                hreadyout_nxt;
    logic                hresp_nxt;
    logic [DATA_W-1:0]   hrdata_nxt;
    logic [NUM_SLV-1:0]  psel_nxt;
    logic                penable_nxt;
    logic [PADDR_W-1:0]  paddr_nxt;
    logic                pwrite_nxt;
    logic [DATA_W-1:0]   pwdata_nxt;

    logic [HADDR_W-1:0]  haddr_c;
    logic                valid_c;
    logic [3:0]          idx_c;
    logic                bad_c;
    logic [NUM_SLV-1:0]  dec_oh_c;
    logic                pready_c;
    logic                pslverr_c;
    logic [DATA_W-1:0]   prdata_c;
    logic                unused_bits;

`ifdef APB_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0]     to_cnt, to_cnt_nxt;
`endif

    assign haddr_c     = bus.haddr;
    assign unused_bits = &{1'b0, bus.htrans[0], haddr_c, 32'(TIMEOUT_CYC)};

    // Address decode and selected-slave response mux (selection held in sel_oh).
    always_comb begin
        valid_c  = bus.hsel & bus.hready & bus.htrans[1];
        idx_c    = haddr_c[SLV_LSB +: 4];
        bad_c    = {1'b0, idx_c} >= 5'(NUM_SLV);
        dec_oh_c = '0;
        prdata_c = '0;
        for (int k = 0; k < int'(NUM_SLV); k++) begin
            dec_oh_c[k] = (idx_c == 4'(k));
            if (sel_oh[k]) begin
                prdata_c = prdata_c | bus.prdata[k*DATA_W +: DATA_W];
            end
        end
        pready_c  = |(bus.pready & sel_oh);
        pslverr_c = |(bus.pslverr & sel_oh);
    end

    // Next state, then every registered output derived from the state being entered.
    always_comb begin
        state_nxt  = state;
        sel_oh_nxt = sel_oh;
        paddr_nxt  = bus.paddr;
        pwrite_nxt = bus.pwrite;
        pwdata_nxt = bus.pwdata;
        hrdata_nxt = bus.hrdata;
`ifdef APB_TIMEOUT_EN
        to_cnt_nxt = to_cnt;
`endif

        case (state)
            S_IDLE: begin
                if (valid_c) begin
                    paddr_nxt  = haddr_c[PADDR_W-1:0];
                    pwrite_nxt = bus.hwrite;
                    sel_oh_nxt = dec_oh_c;
                    if (bad_c) begin
                        state_nxt = S_ERR1;
                    end else if (bus.hwrite) begin
                        state_nxt = S_WWAIT;
                    end else begin
                        state_nxt = S_SETUP;
                    end
                end
            end
            S_WWAIT: begin
                pwdata_nxt = bus.hwdata;
                state_nxt  = S_SETUP;
            end
            S_SETUP: begin
`ifdef APB_TIMEOUT_EN
                to_cnt_nxt = '0;
`endif
                state_nxt = S_ACCESS;
            end
            S_ACCESS: begin
`ifdef APB_TIMEOUT_EN
                to_cnt_nxt = to_cnt + TO_W'(1);
`endif
                if (pready_c) begin
                    if (pslverr_c) begin
                        state_nxt = S_ERR1;
                    end else begin
                        state_nxt = S_IDLE;
                        if (!bus.pwrite) begin
                            hrdata_nxt = prdata_c;
                        end
                    end
                end
`ifdef APB_TIMEOUT_EN
                // A ready arriving on the limit cycle still completes normally.
                else if (to_cnt_nxt == TO_W'(TIMEOUT_CYC)) begin
                    state_nxt = S_ERR1;
                end
`endif
            end
            S_ERR1:  state_nxt = S_ERR2;
            S_ERR2:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase

        hreadyout_nxt = (state_nxt == S_IDLE) || (state_nxt == S_ERR2);
        hresp_nxt     = (state_nxt == S_ERR1) || (state_nxt == S_ERR2);
        penable_nxt   = (state_nxt == S_ACCESS);
        psel_nxt      = ((state_nxt == S_SETUP) || (state_nxt == S_ACCESS)) ? sel_oh_nxt : '0;
    end

    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            state         <= S_IDLE;
            sel_oh        <= '0;
            bus.hreadyout <= 1'b1;
            bus.hresp     <= 1'b0;
            bus.hrdata    <= '0;
            bus.psel      <= '0;
            bus.penable   <= 1'b0;
            bus.paddr     <= '0;
            bus.pwrite    <= 1'b0;
            bus.pwdata    <= '0;
`ifdef APB_TIMEOUT_EN
            to_cnt        <= '0;
`endif
        end else begin
            state         <= state_nxt;
            sel_oh        <= sel_oh_nxt;
            bus.hreadyout <= hreadyout_nxt;
            bus.hresp     <= hresp_nxt;
            bus.hrdata    <= hrdata_nxt;
            bus.psel      <= psel_nxt;
            bus.penable   <= penable_nxt;
            bus.paddr     <= paddr_nxt;
            bus.pwrite    <= pwrite_nxt;
            bus.pwdata    <= pwdata_nxt;
`ifdef APB_TIMEOUT_EN
            to_cnt        <= to_cnt_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_apb_ahb_bridge_core.sv
// Scoreboard bench for apb_ahb_bridge_core: AHB master driver, APB slave model, latency/response checks.
module tb_apb_ahb_bridge_core;

    localparam int unsigned HADDR_W = 32;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned PADDR_W = 16;
    localparam int unsigned NUM_SLV = 4;
    localparam int unsigned SLV_LSB = 12;
    localparam int unsigned TO_CYC  = 4;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          lat;
        logic [3:0]  psel;
        int          psel_cyc;
    } exp_t;

    logic hclk = 1'b0;
    logic hreset_n;

    always #5 hclk = ~hclk;

    apb_ahb_bridge_core_if #(
        .HADDR_W(HADDR_W), .DATA_W(DATA_W), .PADDR_W(PADDR_W), .NUM_SLV(NUM_SLV)
    ) bus ();

    apb_ahb_bridge_core #(
        .HADDR_W(HADDR_W), .DATA_W(DATA_W), .PADDR_W(PADDR_W),
        .NUM_SLV(NUM_SLV), .SLV_LSB(SLV_LSB), .TIMEOUT_CYC(TO_CYC)
    ) dut (
        .hclk    (hclk),
        .hreset_n(hreset_n),
        .bus     (bus)
    );

    int          n_vec = 0;
    int          n_err = 0;
    exp_t        sb[$];
    logic [31:0] model_hrdata = '0;
    int          waits_cfg = 0;
    logic        serr_cfg = 1'b0;
    int          wait_left = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // APB slave array: selected slave stalls waits_cfg ACCESS cycles; unselected slaves
    // show ready and the opposite error flag so a wrong index is visible.
    always @(negedge hclk) begin
        if (bus.psel != '0 && bus.penable) begin
            if (wait_left > 0) begin
                wait_left--;
                bus.pready = ~bus.psel;
            end else begin
                bus.pready = '1;
            end
        end else begin
            wait_left  = waits_cfg;
            bus.pready = '1;
        end
        bus.pslverr = serr_cfg ? bus.psel : ~bus.psel;
    end

    // One AHB transfer, started at a negedge with the bridge in IDLE.
    task automatic xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                        input int waits, input logic serr, input logic [31:0] rdata);
        exp_t e, x;
        int   idx, lat, psel_cyc;
        logic [3:0] psel_or;
        logic ok_apb, resp_prev, resp_cur, done, tmo;
        idx = int'(addr[15:12]);
        tmo = 1'b0;
`ifdef APB_TIMEOUT_EN
        tmo = (idx < 4) && (waits >= int'(TO_CYC));
`endif
        if (idx >= 4) begin
            e.err = 1'b1; e.psel = '0; e.psel_cyc = 0; e.lat = 2;
        end else if (tmo) begin
            e.err = 1'b1; e.psel = 4'(1 << idx); e.psel_cyc = 1 + int'(TO_CYC);
            e.lat = (wr ? 1 : 0) + 1 + int'(TO_CYC) + 2;
        end else begin
            e.err = serr; e.psel = 4'(1 << idx); e.psel_cyc = 2 + waits;
            e.lat = (wr ? 1 : 0) + 2 + waits + (serr ? 2 : 1);
        end
        e.rdata      = (!e.err && !wr) ? rdata : model_hrdata;
        model_hrdata = e.rdata;
        sb.push_back(e);

        waits_cfg = waits;
        serr_cfg  = serr;
        for (int k = 0; k < 4; k++) begin
            bus.prdata[k*32 +: 32] = (k == idx) ? rdata : (32'hDEAD_0000 | 32'(k));
        end
        bus.hsel = 1'b1; bus.hready = 1'b1; bus.htrans = 2'b10;
        bus.hwrite = wr; bus.haddr = addr; bus.hwdata = $urandom;
        @(posedge hclk);

        lat = 0; psel_cyc = 0; psel_or = '0; ok_apb = 1'b1;
        resp_prev = 1'b0; resp_cur = 1'b0; done = 1'b0;
        while (!done && lat < 200) begin
            @(negedge hclk);
            lat++;
            if (lat == 1) begin
                bus.hsel = 1'($urandom); bus.htrans = 2'b00;
                bus.haddr = $urandom; bus.hwdata = wdata;
            end
            resp_prev = resp_cur;
            resp_cur  = bus.hresp;
            if (bus.psel != '0) begin
                psel_cyc++;
                psel_or = psel_or | bus.psel;
                if (bus.paddr !== addr[15:0] || bus.pwrite !== wr ||
                    (wr && bus.pwdata !== wdata) || bus.penable !== (psel_cyc > 1))
                    ok_apb = 1'b0;
            end else if (bus.penable !== 1'b0) begin
                ok_apb = 1'b0;
            end
            if (bus.hreadyout === 1'b1) done = 1'b1;
        end

        x = sb.pop_front();
        chk("latency",     64'(lat),      64'(x.lat));
        chk("hresp",       64'(resp_cur), 64'(x.err));
        chk("hresp_prev",  64'(resp_prev), 64'(x.err));
        chk("hrdata",      64'(bus.hrdata), 64'(x.rdata));
        chk("psel",        64'(psel_or),  64'(x.psel));
        chk("psel_cycles", 64'(psel_cyc), 64'(x.psel_cyc));
        chk("apb_stable",  64'(ok_apb),   64'(1));
        if (x.err) begin
            bus.hsel = 1'b0; bus.htrans = 2'b00;
            @(negedge hclk);
            chk("post_err_ready", 64'(bus.hreadyout), 64'(1));
            chk("post_err_hresp", 64'(bus.hresp), 64'(0));
        end
    endtask

    task automatic idle_cycles(input logic s, input logic r, input logic [1:0] t, input int n);
        bus.hsel = s; bus.hready = r; bus.htrans = t; bus.haddr = 32'h0000_1000;
        for (int i = 0; i < n; i++) begin
            @(negedge hclk);
            chk("idle_ready", 64'(bus.hreadyout), 64'(1));
            chk("idle_hresp", 64'(bus.hresp), 64'(0));
            chk("idle_psel",  64'(bus.psel), 64'(0));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int slv;
        hreset_n = 1'b0;
        bus.hsel = 1'b0; bus.hready = 1'b1; bus.htrans = 2'b00; bus.hwrite = 1'b0;
        bus.haddr = '0; bus.hwdata = '0; bus.prdata = '0;
        repeat (2) @(negedge hclk);
        chk("rst_hreadyout", 64'(bus.hreadyout), 64'(1));
        chk("rst_hresp",     64'(bus.hresp), 64'(0));
        chk("rst_hrdata",    64'(bus.hrdata), 64'(0));
        chk("rst_psel",      64'(bus.psel), 64'(0));
        chk("rst_penable",   64'(bus.penable), 64'(0));
        chk("rst_paddr",     64'(bus.paddr), 64'(0));
        chk("rst_pwrite",    64'(bus.pwrite), 64'(0));
        chk("rst_pwdata",    64'(bus.pwdata), 64'(0));
        hreset_n = 1'b1;
        @(negedge hclk);

        idle_cycles(1'b1, 1'b1, 2'b01, 2);   // BUSY
        idle_cycles(1'b0, 1'b1, 2'b10, 2);   // not selected
        idle_cycles(1'b1, 1'b0, 2'b10, 2);   // hready low
        idle_cycles(1'b0, 1'b1, 2'b00, 1);

        xfer(32'h0000_1010, 1'b0, 32'h0,         0, 1'b0, 32'hCAFE_0001);
        xfer(32'h0000_2004, 1'b1, 32'h1234_5678, 3, 1'b0, 32'h0);
        xfer(32'h0000_0008, 1'b0, 32'h0,         0, 1'b1, 32'h5555_AAAA);
        xfer(32'h0000_5000, 1'b0, 32'h0,         0, 1'b0, 32'h0BAD_0BAD);
        xfer(32'h0000_5000, 1'b1, 32'hFFFF_0000, 0, 1'b0, 32'h0);
        xfer(32'h0000_1000, 1'b0, 32'h0,         0, 1'b0, 32'h1111_2222);
        xfer(32'h0000_3000, 1'b1, 32'hA5A5_5A5A, 0, 1'b0, 32'h0);
        xfer(32'h0000_3FFC, 1'b0, 32'h0,         2, 1'b0, 32'h3333_4444);
        xfer(32'h0000_2010, 1'b1, 32'h0F0F_0F0F, 1, 1'b1, 32'h0);
        xfer(32'h0000_F000, 1'b0, 32'h0,         0, 1'b0, 32'h9999_9999);

`ifdef APB_TIMEOUT_EN
        xfer(32'h0000_1100, 1'b0, 32'h0,         10, 1'b0, 32'h7777_0001);
        xfer(32'h0000_1104, 1'b0, 32'h0,         3,  1'b0, 32'h7777_0002);
        xfer(32'h0000_2200, 1'b1, 32'h0BAD_F00D, 4,  1'b0, 32'h0);
`else
        xfer(32'h0000_1100, 1'b0, 32'h0,         10, 1'b0, 32'h7777_0001);
`endif

        for (int i = 0; i < 12; i++) begin
            slv = $urandom_range(0, 5);
            xfer({16'h0, 4'(slv), 10'($urandom), 2'b00}, 1'($urandom), $urandom,
                 $urandom_range(0, 3), ($urandom_range(0, 4) == 0), $urandom);
        end

        // Reset during ACCESS must drop the APB strobes without waiting for a clock.
        waits_cfg = 6; serr_cfg = 1'b0;
        bus.hsel = 1'b1; bus.hready = 1'b1; bus.htrans = 2'b10;
        bus.hwrite = 1'b0; bus.haddr = 32'h0000_1000;
        @(posedge hclk);
        @(negedge hclk);
        bus.hsel = 1'b0; bus.htrans = 2'b00;
        @(negedge hclk);
        chk("pre_rst_penable", 64'(bus.penable), 64'(1));
        #2 hreset_n = 1'b0;
        #1;
        chk("mid_rst_psel",      64'(bus.psel), 64'(0));
        chk("mid_rst_penable",   64'(bus.penable), 64'(0));
        chk("mid_rst_hreadyout", 64'(bus.hreadyout), 64'(1));
        chk("mid_rst_hresp",     64'(bus.hresp), 64'(0));
        chk("mid_rst_hrdata",    64'(bus.hrdata), 64'(0));
        model_hrdata = '0;
        @(negedge hclk);
        hreset_n = 1'b1;
        @(negedge hclk);
        xfer(32'h0000_0040, 1'b0, 32'h0,         1, 1'b0, 32'h2468_ACE0);
        xfer(32'h0000_3044, 1'b1, 32'h1357_9BDF, 0, 1'b0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
